mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported, one-cycle-read-latency SCC memory between three requesters: CPU instruction fetch, CPU data access, and the boot program loader. It sits between the core/loader and the memory module and issues at most one memory command per cycle. It routes each read response back to the requester that issued it. Arbitration is fixed-priority for the loader and round-robin between fetch and data.

## Interface
Parameters:
- ADDR_W, 32, address width (fixed by ISA)
- DATA_W, 32, data/instruction width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- nreset  in  1  synchronous, active-low reset
- if_req  in  1  instruction fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid
- dm_rdata  out  DATA_W  read data
- ld_req  in  1  loader write request (write only)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader write accepted this cycle
- mem_a  out  ADDR_W  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

## Operation
- Requesters hold req, addr, we and wdata stable until their gnt; gnt is a single-cycle acceptance.
- Grants are combinational from the current reqs plus the registered state. At most one of if_gnt, dm_gnt, ld_gnt is high per cycle.
- Priority:
  - ld_req wins unconditionally.
  - Otherwise a lone request wins.
  - If if_req and dm_req are both high, the side named by the registered pointer rr_favor wins.
- rr_favor updates only on an if or dm grant: it becomes the loser's side. A loader grant leaves it unchanged.
- On a grant, mem_a, mem_we/mem_re and mem_wdata are driven combinationally from the winner in the same cycle. mem_re = winner is a read; mem_we = winner is a write. With no grant: mem_re = mem_we = 0, mem_a = 0, mem_wdata = 0.
- Registered response tag rd_owner ∈ {NONE, IF, DM} is loaded every cycle with the owner of this cycle's read grant, or NONE.
- In the next cycle, rd_owner selects which rvalid pulses. mem_rdata is passed combinationally to both if_rdata and dm_rdata; only the tagged rvalid is high.
- Back-to-back reads are fully pipelined: one grant per cycle, no bubbles.
- Writes complete at grant; no response is generated.

## Timing
- Reset (nreset = 0 at an edge): rr_favor = DM, rd_owner = NONE.
- While nreset = 0, all gnt, mem_re, mem_we and rvalid outputs are forced to 0.
- Read latency: req at cycle N, granted at N → rvalid plus data at N+1.
- Write: granted at N → memory written at the edge ending N.
- Reset asserted the cycle after a read grant: that read's rvalid is suppressed and its response is lost. The requester re-issues after reset.
- Simultaneous rvalid (previous read) and a new grant in the same cycle are legal and independent.
- Persistent ld_req starves if/dm indefinitely, by design (boot only).
- Contended if/dm alternate strictly: each waits at most 1 cycle when ld is idle.

## Structure
- Package mem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_DM, OWN_LD}
  - ADDR_W/DATA_W defaults
  - reset constants RR_FAVOR_RST = OWN_DM
- Sub-module rr_arb2: two-input round-robin arbiter with registered favor bit, inputs req[1:0] and en, output one-hot gnt[1:0]. Instantiated once for if/dm, gated off by ld_req.

## Test plan
- Reset, then if_req only, addr 0x0000_0010, mem returns 0xE3A0_0001 → if_gnt at N, mem_re = 1 with mem_a = 0x10 at N, if_rvalid = 1 and if_rdata = 0xE3A0_0001 at N+1, dm_rvalid = 0.
- if_req and dm_req held together for 4 cycles → grants DM, IF, DM, IF (reset favor DM), rvalids follow one cycle later in the same order.
- ld_req (addr 0x100, data 0xDEAD_BEEF) together with if_req and dm_req → ld_gnt, mem_we = 1, mem_wdata = 0xDEAD_BEEF. rr_favor is unchanged, so the next if/dm contention still grants DM.
- dm write (addr 0x200, data 0x1234_5678), then dm read 0x200 next cycle → dm_rvalid with 0x1234_5678 two cycles after the write grant. No if_rvalid.
- Read granted at N, nreset = 0 at N+1 → no rvalid at N+1. All outputs stay 0 during reset; favor returns to DM.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and reset constants for the SCC memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_LD   = 2'd3
    } owner_t;

    localparam owner_t RR_FAVOR_RST = OWN_DM;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;

    logic [ADDR_W-1:0] mem_a;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               ld_req, ld_addr, ld_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ld_gnt, mem_a, mem_re, mem_we, mem_wdata
    );

    // Requesters plus memory
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               ld_req, ld_addr, ld_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ld_gnt, mem_a, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a registered favor bit picks the winner of a tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // favor_dm = 1: bit 1 wins a tie
    logic favor_dm;
    logic favor_dm_nxt;

    always_ff @(posedge clk) begin
        if (!nreset) favor_dm <= (RR_FAVOR_RST == OWN_DM);
        else         favor_dm <= favor_dm_nxt;
    end

    // Favor moves to the side that did not win, including after a lone grant.
    always_comb begin
        gnt          = 2'b00;
        favor_dm_nxt = favor_dm;
        if (en) begin
            if (req == 2'b11) gnt = favor_dm ? 2'b10 : 2'b01;
            else              gnt = req;
        end
        if (gnt[0])      favor_dm_nxt = 1'b1;
        else if (gnt[1]) favor_dm_nxt = 1'b0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader has fixed priority, fetch/data share round-robin.
//   rd_owner | meaning
//   OWN_NONE | no read issued last cycle, no rvalid
//   OWN_IF   | last cycle's read belongs to fetch, pulse if_rvalid
//   OWN_DM   | last cycle's read belongs to data, pulse dm_rvalid
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    nreset,
    mem_arb_if.slave bus
);

    logic [1:0] rr_gnt;
    logic       arb_en;
    owner_t     rd_owner;
    owner_t     rd_owner_nxt;

    assign arb_en = nreset & ~bus.ld_req;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .nreset (nreset),
        .req    ({bus.dm_req, bus.if_req}),
        .en     (arb_en),
        .gnt    (rr_gnt)
    );

    always_ff @(posedge clk) begin
        if (!nreset) rd_owner <= OWN_NONE;
        else         rd_owner <= rd_owner_nxt;
    end

    always_comb begin
        bus.ld_gnt    = nreset & bus.ld_req;
        bus.if_gnt    = rr_gnt[0];
        bus.dm_gnt    = rr_gnt[1];
        bus.mem_a     = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        rd_owner_nxt  = OWN_NONE;
        if (bus.ld_gnt) begin
            bus.mem_a     = bus.ld_addr;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.ld_wdata;
        end else if (bus.if_gnt) begin
            bus.mem_a     = bus.if_addr;
            bus.mem_re    = 1'b1;
            rd_owner_nxt  = OWN_IF;
        end else if (bus.dm_gnt) begin
            bus.mem_a     = bus.dm_addr;
            bus.mem_re    = ~bus.dm_we;
            bus.mem_we    = bus.dm_we;
            bus.mem_wdata = bus.dm_wdata;
            rd_owner_nxt  = bus.dm_we ? OWN_NONE : OWN_DM;
        end
    end

    // Read data fans out to both requesters; only the tagged rvalid qualifies it.
    assign bus.if_rvalid = nreset & (rd_owner == OWN_IF);
    assign bus.dm_rvalid = nreset & (rd_owner == OWN_DM);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

endmodule
